// File: rtl/omsp_sha512_digest_reader_pkg.sv
// SHA512 digest reader shared definitions.
// Holds the readout state encoding and default digest length.
package omsp_sha512_digest_reader_pkg;

    localparam int unsigned SHA512_DIGEST_WORDS = 16;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SERVE_HI,
        ST_SERVE_LO,
        ST_DONE
    } rd_state_e;

endpackage

// File: rtl/omsp_sha512_digest_reader.sv
// SHA512 digest reader: pulls 32-bit words from the hash core and
// serves them to the CPU as 16-bit halfwords, high half first.
// Ports: clk/rst_n (sync, active-low), start/abort control,
// core_word/core_valid/core_ready core handshake, rd/rd_data/
// data_avail CPU read side, busy/done/underrun status.
module omsp_sha512_digest_reader
    import omsp_sha512_digest_reader_pkg::*;
#(
    parameter int unsigned DIGEST_WORDS = SHA512_DIGEST_WORDS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] core_word,
    input  logic        core_valid,
    output logic        core_ready,
    input  logic        rd,
    output logic [15:0] rd_data,
    output logic        data_avail,
    output logic        busy,
    output logic        done,
    output logic        underrun
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DIGEST_WORDS - 1);

    rd_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      hold_q;
    logic             underrun_q;

    logic last_w;
    logic hs_w;

    assign last_w = (cnt_q == LAST_IDX);

    // Prefetch in SERVE_LO lets the next word land while the low
    // half is consumed, so a continuous rd stream has no bubble.
    always_comb begin
        core_ready = 1'b0;
        if (!abort) begin
            if (state_q == ST_FETCH) begin
                core_ready = 1'b1;
            end else if (state_q == ST_SERVE_LO) begin
                core_ready = rd && !last_w;
            end
        end
    end

    assign hs_w = core_ready && core_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            hold_q     <= '0;
            underrun_q <= 1'b0;
        end else if (abort) begin
            state_q <= ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q    <= ST_FETCH;
                        cnt_q      <= '0;
                        underrun_q <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    if (rd) begin
                        underrun_q <= 1'b1;
                    end
                    if (hs_w) begin
                        hold_q  <= core_word;
                        state_q <= ST_SERVE_HI;
                    end
                end
                ST_SERVE_HI: begin
                    if (rd) begin
                        state_q <= ST_SERVE_LO;
                    end
                end
                ST_SERVE_LO: begin
                    if (rd) begin
                        // Terminal count stops the counter instead
                        // of letting a 16-word readout wrap to 0.
                        if (last_w) begin
                            state_q <= ST_DONE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                            if (hs_w) begin
                                hold_q  <= core_word;
                                state_q <= ST_SERVE_HI;
                            end else begin
                                state_q <= ST_FETCH;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        rd_data = 16'h0000;
        if (state_q == ST_SERVE_HI) begin
            rd_data = hold_q[31:16];
        end else if (state_q == ST_SERVE_LO) begin
            rd_data = hold_q[15:0];
        end
    end

    assign data_avail = (state_q == ST_SERVE_HI) ||
                        (state_q == ST_SERVE_LO);
    assign busy       = (state_q == ST_FETCH) || data_avail;
    assign done       = (state_q == ST_DONE);
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_omsp_sha512_digest_reader.sv
// Testbench for omsp_sha512_digest_reader.
// Count-based reference model plus directed and random stimulus.
module tb_omsp_sha512_digest_reader;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [31:0] core_word;
    logic        core_valid;
    logic        core_ready;
    logic        rd;
    logic [15:0] rd_data;
    logic        data_avail;
    logic        busy;
    logic        done;
    logic        underrun;

    always #5 clk = ~clk;

    omsp_sha512_digest_reader #(.DIGEST_WORDS(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .core_word  (core_word),
        .core_valid (core_valid),
        .core_ready (core_ready),
        .rd         (rd),
        .rd_data    (rd_data),
        .data_avail (data_avail),
        .busy       (busy),
        .done       (done),
        .underrun   (underrun)
    );

    int checks = 0;
    int errors = 0;

    // Model: a readout is a count of words taken from the core and
    // a count of halfwords handed to the CPU.
    logic [31:0] words [N];
    bit          m_started;
    int          m_loaded;
    int          m_halfs;
    bit          m_under;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] half_of(input int h);
        logic [31:0] w;
        if (h / 2 >= N) return 16'h0000;
        w = words[h / 2];
        return (h % 2 == 0) ? w[31:16] : w[15:0];
    endfunction

    task automatic new_words(input logic [31:0] first);
        words[0] = first;
        for (int i = 1; i < N; i++) words[i] = $urandom;
    endtask

    // One clock cycle: drive at negedge, check, then update model.
    task automatic cycle(input bit s, input bit a, input bit r,
                         input bit cv, input bit rn);
        bit busy_e, avail_e, done_e, ready_e;
        logic [15:0] data_e;
        start      = s;
        abort      = a;
        rd         = r;
        core_valid = cv;
        rst_n      = rn;
        core_word  = (m_loaded < N) ? words[m_loaded] : $urandom;
        #1;
        busy_e  = m_started && (m_halfs < 2 * N);
        avail_e = busy_e && (m_halfs < 2 * m_loaded);
        done_e  = m_started && (m_halfs == 2 * N);
        ready_e = !a && busy_e &&
                  ((m_halfs == 2 * m_loaded) ||
                   (m_halfs == 2 * m_loaded - 1 && r &&
                    m_loaded < N));
        data_e  = avail_e ? half_of(m_halfs) : 16'h0000;
        if (rn) begin
            check("core_ready", 32'(core_ready), 32'(ready_e));
            check("data_avail", 32'(data_avail), 32'(avail_e));
            check("rd_data", 32'(rd_data), 32'(data_e));
            check("busy", 32'(busy), 32'(busy_e));
            check("done", 32'(done), 32'(done_e));
            check("underrun", 32'(underrun), 32'(m_under));
        end
        @(posedge clk);
        if (!rn) begin
            m_started = 0;
            m_loaded  = 0;
            m_halfs   = 0;
            m_under   = 0;
        end else if (a) begin
            m_started = 0;
        end else if (!busy_e) begin
            if (s) begin
                m_started = 1;
                m_loaded  = 0;
                m_halfs   = 0;
                m_under   = 0;
            end
        end else begin
            if (r && !avail_e) m_under = 1;
            if (r && avail_e) m_halfs++;
            if (cv && ready_e) m_loaded++;
        end
        @(negedge clk);
    endtask

    task automatic run_to_done(input string tag);
        int k;
        k = 0;
        while (!(m_started && m_halfs == 2 * N) && k < 200) begin
            cycle(0, 0, 1, 1, 1);
            k++;
        end
        check({tag, "_bound"}, 32'(k < 200), 32'd1);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int k;
        int nh;
        start = 0; abort = 0; rd = 0;
        core_valid = 0; core_word = '0; rst_n = 0;
        m_started = 0; m_loaded = 0; m_halfs = 0; m_under = 0;
        new_words(32'h6A09E667);
        @(negedge clk);
        cycle(0, 0, 0, 0, 0);

        // Reset state
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_avail", 32'(data_avail), 32'd0);
        check("rst_data", 32'(rd_data), 32'd0);
        check("rst_under", 32'(underrun), 32'd0);
        cycle(0, 0, 0, 0, 1);

        // First word, immediate core response
        cycle(1, 0, 0, 0, 1);
        cycle(0, 0, 0, 1, 1);
        check("w0_avail", 32'(data_avail), 32'd1);
        check("w0_hi", 32'(rd_data), 32'h6A09);
        cycle(0, 0, 1, 0, 1);
        check("w0_lo", 32'(rd_data), 32'hE667);
        cycle(0, 1, 0, 0, 1);

        // Streaming readout, rd held high
        new_words($urandom);
        cycle(1, 0, 0, 0, 1);
        cycle(0, 0, 0, 1, 1);
        nh = 0;
        k = 0;
        while (data_avail && k < 100) begin
            cycle(0, 0, 1, 1, 1);
            nh++;
            k++;
        end
        check("stream_halfs", 32'(nh), 32'(2 * N));
        check("stream_done", 32'(done), 32'd1);
        check("stream_busy", 32'(busy), 32'd0);

        // Underrun in FETCH, sticky through DONE
        new_words($urandom);
        cycle(1, 0, 0, 0, 1);
        cycle(0, 0, 1, 0, 1);
        check("ur_set", 32'(underrun), 32'd1);
        run_to_done("ur");
        check("ur_keep", 32'(underrun), 32'd1);
        cycle(1, 0, 0, 0, 1);
        check("ur_clear", 32'(underrun), 32'd0);

        // Abort in SERVE_LO of word 5 with rd and core_valid
        new_words($urandom);
        k = 0;
        while (!(m_halfs == 11 && m_loaded == 6) && k < 100) begin
            cycle(0, 0, 1, 1, 1);
            k++;
        end
        check("ab_reach", 32'(k < 100), 32'd1);
        check("ab_serve_lo", 32'(rd_data), 32'(words[5][15:0]));
        cycle(0, 1, 1, 1, 1);
        check("ab_busy", 32'(busy), 32'd0);
        check("ab_avail", 32'(data_avail), 32'd0);

        // Reset during SERVE_HI, then restart from word 0
        new_words($urandom);
        cycle(1, 0, 0, 0, 1);
        cycle(0, 0, 0, 1, 1);
        check("rs_hi", 32'(rd_data), 32'(words[0][31:16]));
        cycle(1, 0, 1, 1, 0);
        check("rs_busy", 32'(busy), 32'd0);
        check("rs_avail", 32'(data_avail), 32'd0);
        check("rs_data", 32'(rd_data), 32'd0);
        check("rs_ready", 32'(core_ready), 32'd0);
        cycle(1, 0, 0, 0, 1);
        cycle(0, 0, 0, 1, 1);
        check("rs_w0", 32'(rd_data), 32'(words[0][31:16]));
        run_to_done("rs");

        // Start pulses while busy are ignored
        new_words($urandom);
        cycle(1, 0, 0, 0, 1);
        k = 0;
        while (!(m_halfs == 2 * N) && k < 300) begin
            cycle(1, 0, ($urandom_range(0, 2) != 0), 1, 1);
            k++;
        end
        check("sb_done", 32'(done), 32'd1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bit s, a, r, cv, rn;
            if (m_started && m_halfs == 2 * N) new_words($urandom);
            if (!m_started) new_words($urandom);
            s  = ($urandom_range(0, 9) == 0);
            a  = ($urandom_range(0, 79) == 0);
            r  = ($urandom_range(0, 2) != 0);
            cv = ($urandom_range(0, 3) != 0);
            rn = ($urandom_range(0, 199) != 0);
            cycle(s, a, r, cv, rn);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/omsp_sha512_digest_reader.md
OMSP_SHA512_DIGEST_READER -- requirements
Module: omsp_sha512_digest_reader

Interface
REQ-001 SHALL have parameter DIGEST_WORDS, default 16, number of 32-bit digest words per readout (legal range 1..16).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a digest readout.
REQ-005 SHALL have port abort  input  1  cancels any readout in progress.
REQ-006 SHALL have port core_word  input  32  digest word from the hash core.
REQ-007 SHALL have port core_valid  input  1  core_word valid.
REQ-008 SHALL have port core_ready  output  1  reader accepts core_word this cycle.
REQ-009 SHALL have port rd  input  1  CPU read strobe, consumes one 16-bit halfword.
REQ-010 SHALL have port rd_data  output  16  current halfword.
REQ-011 SHALL have port data_avail  output  1  rd_data valid.
REQ-012 SHALL have port busy  output  1  readout in progress.
REQ-013 SHALL have port done  output  1  all DIGEST_WORDS words delivered.
REQ-014 SHALL have port underrun  output  1  sticky: rd seen while data_avail=0 during a readout.

Function
REQ-015 SHALL implement states IDLE, FETCH, SERVE_HI, SERVE_LO and DONE.
REQ-016 IDLE/DONE: start=1 -> FETCH next cycle; word counter cleared to 0; underrun cleared; done cleared.
REQ-017 FETCH: core_ready=1; core_valid=1 -> word latched into the holding register and SERVE_HI next cycle (one-cycle latency from handshake to data_avail).
REQ-018 SERVE_HI: data_avail=1, rd_data=hold[31:16]; rd=1 -> SERVE_LO next cycle.
REQ-019 SERVE_LO: data_avail=1, rd_data=hold[15:0]; rd=1 -> counter incremented, then FETCH, or DONE if counter was DIGEST_WORDS-1.
REQ-020 Prefetch: in SERVE_LO, core_ready=1 only when rd=1 and the word is not the last; a simultaneous core handshake loads the next word and the next state is SERVE_HI, so no bubble occurs.
REQ-021 core_ready=0 in IDLE, SERVE_HI and DONE, and in SERVE_LO whenever REQ-020 does not apply.
REQ-022 rd_data=0 whenever data_avail=0.
REQ-023 busy=1 in FETCH, SERVE_HI and SERVE_LO only.
REQ-024 done=1 level in DONE until the next start or abort.
REQ-025 rd while busy=1 and data_avail=0 -> underrun=1 next cycle, held until start; rd in IDLE/DONE ignored, no flag.
REQ-026 start while busy=1 SHALL be ignored.
REQ-027 abort=1 -> IDLE next cycle from any state, with priority over start, rd and core handshake; any core_word presented that cycle is not accepted (core_ready=0).
REQ-028 Counter width SHALL be 4 bits and SHALL never wrap: the terminal count selects DONE.

Reset
REQ-029 rst_n=0 at a clock edge -> IDLE, counter=0, hold=0, underrun=0; outputs core_ready, data_avail, busy and done are 0 and rd_data is 0.
REQ-030 Reset SHALL override start, abort, rd and core handshake in the same cycle, including mid-readout.

Structure
REQ-031 State encoding and the DIGEST_WORDS default SHALL live in the shared SHA512 package.
REQ-032 The design SHALL be a single module with no sub-modules; the halfword select is inline.

Verification
REQ-033 Reset, then start; core supplies 0x6A09E667 immediately -> data_avail at handshake+1, rd_data=0x6A09; after rd, rd_data=0xE667.
REQ-034 Full readout with DIGEST_WORDS=16 and rd held high, core always valid -> 32 halfwords on consecutive cycles after the first, then done=1 and busy=0.
REQ-035 rd pulsed in FETCH before core_valid -> underrun=1; it stays 1 through DONE and clears on the next start.
REQ-036 abort asserted in SERVE_LO of word 5 together with rd and core_valid -> IDLE next cycle, core_ready=0 that cycle, busy=0.
REQ-037 rst_n=0 during SERVE_HI -> next cycle all outputs 0; a following start restarts at word 0.
REQ-038 start pulsed while busy -> no effect; the counter and the order of delivered halfwords are unchanged.
